// File: rtl/qerv_operand_ser.sv
// rtl/qerv_operand_ser.sv - serializes two 32-bit operands into W-bit chunks for the bit-serial ALU and reassembles its result word
module qerv_operand_ser #(
    parameter int W = 1,
    parameter int B = W - 1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_op_b,
    output logic        o_en,
    output logic        o_cnt0,
    output logic        o_cnt_last,
    output logic [B:0]  o_rs1,
    output logic [B:0]  o_op_b,
    input  logic [B:0]  i_rd,
    input  logic        i_cmp,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_rd,
    output logic        o_cmp
);

    localparam int         N        = 32 / W;
    localparam logic [4:0] CNT_LAST = 5'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [31:0] rs1_sr;
    logic [31:0] opb_sr;
    logic [31:0] rd_sr;
    logic        cmp_q;
    logic        accept;
    logic        running;
    logic        last;

    assign accept  = (state == IDLE) & i_valid;
    assign running = (state == RUN);
    assign last    = running & (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_valid) state_nxt = RUN;
            RUN:  if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result enters at the top so that after N chunks the first one lands in bits [B:0].
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            rs1_sr <= '0;
            opb_sr <= '0;
            rd_sr  <= '0;
            cmp_q  <= 1'b0;
        end else if (accept) begin
            rs1_sr <= i_rs1;
            opb_sr <= i_op_b;
            cnt    <= '0;
        end else if (running) begin
            rs1_sr <= rs1_sr >> W;
            opb_sr <= opb_sr >> W;
            rd_sr  <= {i_rd, rd_sr[31:W]};
            if (last) begin
                cmp_q <= i_cmp;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end
    end

    assign o_ready    = (state == IDLE);
    assign o_en       = running;
    assign o_cnt0     = running & (cnt == 5'd0);
    assign o_cnt_last = last;
    assign o_rs1      = running ? rs1_sr[B:0] : '0;
    assign o_op_b     = running ? opb_sr[B:0] : '0;
    assign o_valid    = (state == DONE);
    assign o_rd       = rd_sr;
    assign o_cmp      = cmp_q;

endmodule

// File: tb/tb_qerv_operand_ser.sv
// tb/tb_qerv_operand_ser.sv - directed bench for qerv_operand_ser at W=4 and W=1
module tb_qerv_operand_ser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        v4, rdy4, en4, c0_4, cl4, cmp_in4, ov4, ir4, ocmp4;
    logic [31:0] rs1_4, opb_4, ord4;
    logic [3:0]  ors1_4, oopb_4, ird4;
    int          cmp_mode;

    assign ird4    = ors1_4 ^ oopb_4;
    assign cmp_in4 = (cmp_mode == 1) ? cl4 : (cmp_mode == 2) ? ~cl4 : 1'b0;

    qerv_operand_ser #(.W(4)) dut4 (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_valid    (v4),
        .o_ready    (rdy4),
        .i_rs1      (rs1_4),
        .i_op_b     (opb_4),
        .o_en       (en4),
        .o_cnt0     (c0_4),
        .o_cnt_last (cl4),
        .o_rs1      (ors1_4),
        .o_op_b     (oopb_4),
        .i_rd       (ird4),
        .i_cmp      (cmp_in4),
        .o_valid    (ov4),
        .i_ready    (ir4),
        .o_rd       (ord4),
        .o_cmp      (ocmp4)
    );

    logic        v1, rdy1, en1, c0_1, cl1, ov1, ir1, ocmp1;
    logic [31:0] rs1_1, opb_1, ord1;
    logic [0:0]  ors1_1, oopb_1, ird1;

    assign ird1 = ors1_1;

    qerv_operand_ser #(.W(1)) dut1 (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_valid    (v1),
        .o_ready    (rdy1),
        .i_rs1      (rs1_1),
        .i_op_b     (opb_1),
        .o_en       (en1),
        .o_cnt0     (c0_1),
        .o_cnt_last (cl1),
        .o_rs1      (ors1_1),
        .o_op_b     (oopb_1),
        .i_rd       (ird1),
        .i_cmp      (1'b0),
        .o_valid    (ov1),
        .i_ready    (ir1),
        .o_rd       (ord1),
        .o_cmp      (ocmp1)
    );

    int n_pass  = 0;
    int n_total = 0;

    int          lat;
    int          en_n;
    logic [31:0] c0_mask;
    logic [31:0] last_mask;
    logic [31:0] seq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called at posedge+1; returns in the first cycle with o_valid high (or after the bound).
    task automatic start_op4(input logic [31:0] a, input logic [31:0] b);
        lat       = 0;
        en_n      = 0;
        c0_mask   = '0;
        last_mask = '0;
        seq       = '0;
        v4    = 1'b1;
        rs1_4 = a;
        opb_4 = b;
        ir4   = 1'b0;
        @(posedge clk); #1;
        v4    = 1'b0;
        rs1_4 = 32'hA5A5A5A5;
        opb_4 = ~b;
        for (int k = 1; k <= 50; k++) begin
            if (ov4) begin
                lat = k;
                break;
            end
            if (en4) begin
                en_n++;
                seq = {seq[27:0], ors1_4};
            end
            if (k < 32) begin
                if (c0_4) c0_mask[k] = 1'b1;
                if (cl4)  last_mask[k] = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_op4();
        ir4 = 1'b1;
        @(posedge clk); #1;
        ir4 = 1'b0;
    endtask

    logic [31:0] held_rd;
    logic        held_cmp;
    logic        stable;
    int          lat1;
    int          en1_n;

    initial begin
        rst_n = 1'b0;
        v4 = 1'b0; rs1_4 = '0; opb_4 = '0; ir4 = 1'b0; cmp_mode = 0;
        v1 = 1'b0; rs1_1 = '0; opb_1 = '0; ir1 = 1'b0;

        #3;
        check("rst_ready", {31'd0, rdy4}, 32'd1);
        check("rst_en", {29'd0, en4, c0_4, cl4}, 32'd0);
        check("rst_valid", {31'd0, ov4}, 32'd0);
        check("rst_rd", ord4, 32'd0);
        check("rst_cmp", {31'd0, ocmp4}, 32'd0);
        check("rst_chunks", {24'd0, ors1_4, oopb_4}, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {31'd0, rdy4}, 32'd1);
        check("post_rst_valid", {31'd0, ov4}, 32'd0);
        @(posedge clk); #1;

        // Result of chunkwise xor: 0x12345678 ^ 0x0F0F0F0F = 0x1D3B5977
        cmp_mode = 1;
        start_op4(32'h12345678, 32'h0F0F0F0F);
        check("w4_latency", lat, 32'd9);
        check("w4_rd", ord4, 32'h1D3B5977);
        check("w4_rs1_seq", seq, 32'h87654321);
        check("w4_en_cycles", en_n, 32'd8);
        check("w4_cnt0_mask", c0_mask, 32'h0000_0002);
        check("w4_last_mask", last_mask, 32'h0000_0100);
        check("cmp_on_last", {31'd0, ocmp4}, 32'd1);

        held_rd  = ord4;
        held_cmp = ocmp4;
        stable   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v4 = (i % 2 == 0);
            @(posedge clk); #1;
            if (ord4 !== held_rd || ocmp4 !== held_cmp || rdy4 !== 1'b0 || ov4 !== 1'b1)
                stable = 1'b0;
        end
        v4 = 1'b0;
        check("bp_hold", {31'd0, stable}, 32'd1);
        finish_op4();
        check("bp_ready_after", {31'd0, rdy4}, 32'd1);
        check("bp_valid_after", {31'd0, ov4}, 32'd0);

        cmp_mode = 2;
        start_op4(32'h12345678, 32'h0F0F0F0F);
        check("cmp_not_last", {31'd0, ocmp4}, 32'd0);
        check("w4_rd_again", ord4, 32'h1D3B5977);
        finish_op4();
        cmp_mode = 0;

        // Reset during RUN cycle 4.
        v4 = 1'b1; rs1_4 = 32'h12345678; opb_4 = 32'h0F0F0F0F;
        @(posedge clk); #1;
        v4 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_en", {31'd0, en4}, 32'd1);
        check("mid_partial_nz", {31'd0, (ord4 != 32'd0)}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_en", {31'd0, en4}, 32'd0);
        check("async_rd", ord4, 32'd0);
        check("async_valid", {31'd0, ov4}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rel_ready", {31'd0, rdy4}, 32'd1);
        @(posedge clk); #1;
        start_op4(32'hFFFF0000, 32'hAAAAAAAA);
        check("after_rst_latency", lat, 32'd9);
        check("after_rst_rd", ord4, 32'h5555AAAA);
        finish_op4();

        // W=1 pass-through of operand A.
        lat1  = 0;
        en1_n = 0;
        v1 = 1'b1; rs1_1 = 32'hDEADBEEF; opb_1 = 32'h0;
        @(posedge clk); #1;
        v1 = 1'b0; rs1_1 = 32'h0;
        for (int k = 1; k <= 60; k++) begin
            if (ov1) begin
                lat1 = k;
                break;
            end
            if (en1) en1_n++;
            @(posedge clk); #1;
        end
        check("w1_latency", lat1, 32'd33);
        check("w1_en_cycles", en1_n, 32'd32);
        check("w1_rd", ord1, 32'hDEADBEEF);
        ir1 = 1'b1;
        @(posedge clk); #1;
        ir1 = 1'b0;
        check("w1_ready_after", {31'd0, rdy1}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
